// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Module-level widths come from the helpers so each instance sizes itself.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int NREQ_DEF  = 4;
   localparam int BURST_DEF = 8;
   localparam int IDXW      = $clog2(NREQ_DEF);
   localparam int CNTW      = $clog2(BURST_DEF + 1);

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int b);
      return $clog2(b + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first asserted request searching upward from last+1.
// Purely combinational; wraps at NREQ-1 so non-power-of-two counts work.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [IW-1:0]   idx,
   output logic            found
);

   logic [IW-1:0] j;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      j     = last;
      for (int k = 0; k < NREQ; k++) begin
         j = (j == IW'(NREQ - 1)) ? '0 : j + IW'(1);
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port (wclk domain).
// winc is gated combinationally by wfull so the FIFO is never overwritten.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int BURST = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         ack,
   output logic                    winc,
   output logic [WIDTH-1:0]        wdata,
   input  logic                    wfull,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy
);

   localparam int IW = idx_w(NREQ);
   localparam int CW = cnt_w(BURST);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] pick_idx;
   logic [CW-1:0] bcnt_q, bcnt_d;
   logic          pick_found;
   logic          xfer;
   logic          done;

   logic [WIDTH-1:0] dv [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign dv[i] = data[i*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign xfer = (state_q == GRANT) && req[owner_q] && !wfull;
   assign done = (bcnt_q + CW'(1)) == CW'(BURST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IW'(NREQ - 1);
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         bcnt_q  <= bcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      bcnt_d  = bcnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               bcnt_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // a dropped request ends the grant; wfull alone only stalls it
            if (!req[owner_q]) begin
               state_d = IDLE;
               last_d  = owner_q;
            end else if (xfer) begin
               if (done) begin
                  state_d = IDLE;
                  last_d  = owner_q;
                  bcnt_d  = '0;
               end else begin
                  bcnt_d = bcnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack   = '0;
      winc  = 1'b0;
      wdata = '0;
      owner = '0;
      busy  = 1'b0;
      if (!rst) begin
         owner = owner_q;
         busy  = (state_q == GRANT);
         winc  = xfer;
         if (xfer) begin
            ack[owner_q] = 1'b1;
            wdata        = dv[owner_q];
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences.
module tb_fifo_wr_arbiter;

   localparam logic [31:0] D0 = 32'hA000_0000;
   localparam logic [31:0] D1 = 32'hB111_1111;
   localparam logic [31:0] D2 = 32'hC222_2222;
   localparam logic [31:0] D3 = 32'hD333_3333;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [127:0] data;
   logic [3:0]  ack;
   logic        winc;
   logic [31:0] wdata;
   logic        wfull = 1'b0;
   logic [1:0]  owner;
   logic        busy;

   logic        rst2 = 1'b1;
   logic [1:0]  req2 = '0;
   logic [63:0] data2;
   logic [1:0]  ack2;
   logic        winc2;
   logic [31:0] wdata2;
   logic        wfull2 = 1'b0;
   logic [0:0]  owner2;
   logic        busy2;

   int n_pass = 0;
   int n_tot  = 0;

   logic [31:0] dtab [4];

   assign data  = {D3, D2, D1, D0};
   assign data2 = {D1, D0};

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.WIDTH(32), .NREQ(4), .BURST(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .data  (data),
      .ack   (ack),
      .winc  (winc),
      .wdata (wdata),
      .wfull (wfull),
      .owner (owner),
      .busy  (busy)
   );

   fifo_wr_arbiter #(.WIDTH(32), .NREQ(2), .BURST(1)) dut2 (
      .clk   (clk),
      .rst   (rst2),
      .req   (req2),
      .data  (data2),
      .ack   (ack2),
      .winc  (winc2),
      .wdata (wdata2),
      .wfull (wfull2),
      .owner (owner2),
      .busy  (busy2)
   );

   typedef struct {
      logic       r;
      logic [3:0] rq;
      logic       wf;
      logic [3:0] a;
      logic       w;
      logic       b;
      logic [1:0] o;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic drv(input logic r, input logic [3:0] rq, input logic wf);
      @(negedge clk);
      rst   = r;
      req   = rq;
      wfull = wf;
      #1;
      chk("no_winc_when_full", 32'(winc & wfull), 32'd0);
   endtask

   task automatic drv2(input logic r, input logic [1:0] rq);
      @(negedge clk);
      rst2 = r;
      req2 = rq;
      #1;
   endtask

   task automatic exp_out(input string tag, input logic [3:0] a,
                          input logic w, input logic b, input logic [1:0] o);
      logic [31:0] ew;
      ew = w ? dtab[o] : 32'd0;
      chk({tag, "_ack"},   32'(ack),   32'(a));
      chk({tag, "_winc"},  32'(winc),  32'(w));
      chk({tag, "_busy"},  32'(busy),  32'(b));
      chk({tag, "_owner"}, 32'(owner), 32'(o));
      chk({tag, "_wdata"}, wdata,      ew);
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic wf,
                      input logic [3:0] a, input logic w, input logic b,
                      input logic [1:0] o);
      vec_t v;
      v.r = r; v.rq = rq; v.wf = wf;
      v.a = a; v.w = w; v.b = b; v.o = o;
      tbl.push_back(v);
   endtask

   initial begin
      int seq [5];
      int occ;
      int nwr;
      logic [31:0] sb[$];
      logic [0:0]  eo;

      dtab[0] = D0; dtab[1] = D1; dtab[2] = D2; dtab[3] = D3;

      // reset, single requester burst, re-grant, drop release
      add(1, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
      add(0, 4'b0001, 0, 4'b0000, 0, 0, 2'd0);
      for (int i = 0; i < 8; i++)
         add(0, 4'b0001, 0, 4'b0001, 1, 1, 2'd0);
      add(0, 4'b0001, 0, 4'b0000, 0, 0, 2'd0);
      add(0, 4'b0001, 0, 4'b0001, 1, 1, 2'd0);
      add(0, 4'b0000, 0, 4'b0000, 0, 1, 2'd0);
      add(0, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
      // owner 1 drops after two beats; 2 is skipped, 3 then 0
      add(0, 4'b0010, 0, 4'b0000, 0, 0, 2'd0);
      add(0, 4'b1010, 0, 4'b0010, 1, 1, 2'd1);
      add(0, 4'b1010, 0, 4'b0010, 1, 1, 2'd1);
      add(0, 4'b1000, 0, 4'b0000, 0, 1, 2'd1);
      add(0, 4'b1001, 0, 4'b0000, 0, 0, 2'd1);
      add(0, 4'b1001, 0, 4'b1000, 1, 1, 2'd3);
      add(0, 4'b0001, 0, 4'b0000, 0, 1, 2'd3);
      add(0, 4'b0001, 0, 4'b0000, 0, 0, 2'd3);
      add(0, 4'b0001, 0, 4'b0001, 1, 1, 2'd0);
      add(0, 4'b0000, 0, 4'b0000, 0, 1, 2'd0);
      add(0, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);

      foreach (tbl[k]) begin
         drv(tbl[k].r, tbl[k].rq, tbl[k].wf);
         exp_out($sformatf("vec%0d", k), tbl[k].a, tbl[k].w, tbl[k].b,
                 tbl[k].o);
      end

      // all four requesting: 0,1,2,3,0 with 8 beats each
      seq = '{0, 1, 2, 3, 0};
      drv(1, 4'b0000, 0);
      for (int g = 0; g < 5; g++) begin
         drv(0, 4'b1111, 0);
         chk($sformatf("rr%0d_idle_busy", g), 32'(busy), 32'd0);
         chk($sformatf("rr%0d_idle_winc", g), 32'(winc), 32'd0);
         for (int b = 0; b < 8; b++) begin
            drv(0, 4'b1111, 0);
            exp_out($sformatf("rr%0d_b%0d", g, b),
                    4'(4'b0001 << seq[g]), 1, 1, 2'(seq[g]));
         end
      end
      drv(0, 4'b0000, 0);

      // wfull stall at beat 3 of owner 2
      occ = 56;
      nwr = 0;
      drv(1, 4'b0000, 0);
      drv(0, 4'b0100, 0);
      exp_out("st_idle", 4'b0000, 0, 0, 2'd0);
      for (int b = 0; b < 13; b++) begin
         logic stall;
         stall = (b >= 3) && (b < 8);
         drv(0, 4'b0100, stall);
         if (stall) begin
            exp_out($sformatf("st_hold%0d", b), 4'b0000, 0, 1, 2'd2);
            chk($sformatf("st_bcnt%0d", b), 32'(dut.bcnt_q), 32'd3);
         end else begin
            exp_out($sformatf("st_beat%0d", b), 4'b0100, 1, 1, 2'd2);
         end
         if (winc) begin
            nwr++;
            occ++;
         end
         chk($sformatf("st_nooverflow%0d", b), 32'(occ > 64), 32'd0);
      end
      chk("st_writes", 32'(nwr), 32'd8);
      drv(0, 4'b0100, 0);
      exp_out("st_release", 4'b0000, 0, 0, 2'd2);
      drv(0, 4'b0000, 0);

      // reset at beat 5 of owner 2
      drv(1, 4'b0000, 0);
      drv(0, 4'b0100, 0);
      for (int b = 0; b < 4; b++) begin
         drv(0, 4'b0100, 0);
         exp_out($sformatf("rs_beat%0d", b), 4'b0100, 1, 1, 2'd2);
      end
      drv(1, 4'b0100, 0);
      exp_out("rs_inrst", 4'b0000, 0, 0, 2'd0);
      drv(0, 4'b1000, 0);
      exp_out("rs_after", 4'b0000, 0, 0, 2'd0);
      drv(0, 4'b1000, 0);
      exp_out("rs_regrant", 4'b1000, 1, 1, 2'd3);
      drv(0, 4'b0000, 0);

      // NREQ=2, BURST=1: strict alternation
      sb = '{D0, D1, D0, D1};
      drv2(1, 2'b00);
      for (int c = 0; c < 8; c++) begin
         drv2(0, 2'b11);
         eo = 1'((c / 2) % 2);
         chk($sformatf("alt%0d_winc", c), 32'(winc2), 32'(c % 2));
         if (c % 2 == 1) begin
            chk($sformatf("alt%0d_owner", c), 32'(owner2), 32'(eo));
            chk($sformatf("alt%0d_ack", c), 32'(ack2),
                32'(2'(2'b01 << eo)));
         end
         if (winc2) begin
            if (sb.size() == 0) begin
               chk($sformatf("alt%0d_extra", c), 32'd1, 32'd0);
            end else begin
               chk($sformatf("alt%0d_data", c), wdata2, sb.pop_front());
            end
         end
      end
      chk("alt_drained", 32'(sb.size()), 32'd0);
      drv2(0, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
